// File: rtl/loctag_adc_rx_if.sv
// -----------------------------------------------------------------------------
// loctag_adc_rx_if
// Serial ADC bus between the loctag receiver and a 12-bit SPI-style ADC.
//   adc_cs  : chip select, active-low, driven by the receiver
//   adc_clk : serial clock, idles high, driven by the receiver
//   adc_so  : serial data from the ADC, MSB first, synchronous to clk
// Modports: master = receiver side, slave = ADC side.
// -----------------------------------------------------------------------------
interface loctag_adc_rx_if;
  logic adc_cs;
  logic adc_clk;
  logic adc_so;

  modport master (output adc_cs, output adc_clk, input adc_so);
  modport slave  (input adc_cs, input adc_clk, output adc_so);
endinterface

// File: rtl/loctag_adc_rx.sv
// -----------------------------------------------------------------------------
// loctag_adc_rx
// Runs back-to-back conversions on a serial 12-bit ADC that reports the RF
// detector envelope, presents each result and flags when it reaches a
// programmable threshold for the loctag trigger logic.
//
// Ports:
//   clk            : system clock, rising edge
//   reset          : asynchronous reset, active-low
//   en_i           : high = keep converting
//   threshold_i    : detection level, compared unsigned against each new sample
//   sample_o       : latest converted value, held between updates
//   sample_valid_o : one-cycle pulse when sample_o updates
//   above_o        : sample_o >= threshold_i (threshold taken at the update)
//   frame_err_o    : a leading-zero bit of the last frame read as 1
//   adc            : serial ADC bus (master side)
//
// Parameters:
//   CLK_DIV   : clk cycles per adc_clk half-period (1..255)
//   QUIET_CYC : clk cycles with adc_cs high between frames (1..255)
//
// Build option LOCTAG_ADC_AVG_EN: when defined, sample_o is the truncated mean
// of the last four raw frames instead of the raw frame value.
// -----------------------------------------------------------------------------
module loctag_adc_rx #(
  parameter int CLK_DIV   = 2,
  parameter int QUIET_CYC = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [11:0]           threshold_i,
  output logic [11:0]           sample_o,
  output logic                  sample_valid_o,
  output logic                  above_o,
  output logic                  frame_err_o,
  loctag_adc_rx_if.master       adc
);

  localparam logic [7:0] DIV_TC   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_TC = 8'(QUIET_CYC - 1);

  typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic [4:0]  edge_q, edge_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  quiet_q, quiet_d;
  logic        done_q, done_d;

  logic [11:0] sample_q;
  logic        valid_q;
  logic        above_q;
  logic        ferr_q;

  logic [11:0] raw;
  logic [11:0] new_sample;

  function automatic logic [11:0] avg4(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c, input logic [11:0] d);
    logic [13:0] sum;
    sum = 14'(a) + 14'(b) + 14'(c) + 14'(d);
    return sum[13:2];
  endfunction

  // Next-state logic. Divider, serial clock and bit counter sit at their idle
  // values whenever the FSM is outside CONV, so every frame starts clean.
  always_comb begin
    state_d = state_q;
    div_d   = 8'd0;
    sclk_d  = 1'b1;
    edge_d  = 5'd0;
    shift_d = shift_q;
    quiet_d = 8'd0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = CONV;
      end
      CONV: begin
        sclk_d = sclk_q;
        edge_d = edge_q;
        div_d  = div_q + 8'd1;
        if (div_q == DIV_TC) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Data is captured in the cycle that drives adc_clk 0->1.
          if (!sclk_q) begin
            shift_d = {shift_q[14:0], adc.adc_so};
            edge_d  = edge_q + 5'd1;
            if (edge_q == 5'd15) begin
              state_d = QUIET;
              done_d  = 1'b1;
            end
          end
        end
      end
      QUIET: begin
        quiet_d = quiet_q + 8'd1;
        if (quiet_q == QUIET_TC) begin
          quiet_d = 8'd0;
          state_d = en_i ? CONV : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      sclk_q  <= 1'b1;
      edge_q  <= 5'd0;
      shift_q <= 16'd0;
      quiet_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      quiet_q <= quiet_d;
      done_q  <= done_d;
    end
  end

  assign raw = shift_q[11:0];

`ifdef LOCTAG_ADC_AVG_EN
  logic [11:0] hist1_q, hist2_q, hist3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist1_q <= 12'd0;
      hist2_q <= 12'd0;
      hist3_q <= 12'd0;
    end else if (done_q) begin
      hist1_q <= raw;
      hist2_q <= hist1_q;
      hist3_q <= hist2_q;
    end
  end

  assign new_sample = avg4(raw, hist1_q, hist2_q, hist3_q);
`else
  assign new_sample = raw;
`endif

  // Result stage: one cycle after the frame's last capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= 12'd0;
      valid_q  <= 1'b0;
      above_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= done_q;
      if (done_q) begin
        sample_q <= new_sample;
        above_q  <= (new_sample >= threshold_i);
        ferr_q   <= |shift_q[15:12];
      end
    end
  end

  assign adc.adc_cs     = (state_q != CONV);
  assign adc.adc_clk    = sclk_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign above_o        = above_q;
  assign frame_err_o    = ferr_q;

endmodule

// File: doc/loctag_adc_rx.md
LOCTAG_ADC_RX -- requirements
Module: loctag_adc_rx

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per adc_clk half-period; legal range 1..255.
REQ-002 Parameter QUIET_CYC, default 20: clk cycles with adc_cs high between frames; legal range 1..255.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  high = run back-to-back conversions.
REQ-006 adc_cs  output  1  ADC chip select, active-low.
REQ-007 adc_clk  output  1  ADC serial clock, idles high.
REQ-008 adc_so  input  1  ADC serial data, MSB first; already synchronous to clk.
REQ-009 threshold  input  12  detection level for the RF detector envelope.
REQ-010 sample  output  12  latest converted value, held between updates.
REQ-011 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-012 above  output  1  registered flag, sample >= threshold; feeds the loctag trigger logic.
REQ-013 frame_err  output  1  registered flag, any leading-zero bit read as 1 in the last frame.

Function
REQ-014 FSM states: IDLE, CONV, QUIET; encoding free.
- IDLE -> CONV when en=1.
- CONV -> QUIET after the 16th adc_clk rising edge.
- QUIET -> CONV after QUIET_CYC cycles if en=1, else QUIET -> IDLE.
REQ-015 adc_cs is low in every cycle spent in CONV and high in all other states.
REQ-016 adc_clk generation in CONV: a divider counts 0..CLK_DIV-1 and toggles adc_clk at terminal count, starting from high.
- Each frame has exactly 16 falling and 16 rising edges.
- adc_cs is low for exactly 32*CLK_DIV cycles.
REQ-017 adc_so is sampled in the clk cycle in which adc_clk is driven 0->1, and shifted into a 16-bit register, MSB first.
REQ-018 Frame bits: bits 15..12 are leading zeros; sample = bits 11..0.
REQ-019 sample, frame_err and above update together, one cycle after the CONV->QUIET transition, with sample_valid=1 in that same cycle.
REQ-020 above uses the new sample value, unsigned 12-bit compare.
REQ-021 en falling mid-frame: the frame completes normally and produces sample_valid, then the block returns to IDLE via QUIET.
REQ-022 en=0 in IDLE: adc_clk=1, adc_cs=1, no sample_valid.
REQ-023 threshold changes take effect at the next sample_valid only.

Reset
REQ-024 On reset low, immediately and mid-frame included:
- state = IDLE, adc_cs=1, adc_clk=1;
- sample=0, sample_valid=0, above=0, frame_err=0;
- shift register, divider and bit counter cleared.
REQ-025 No partial-frame data is ever presented after reset release.

Configuration
REQ-026 Macro LOCTAG_ADC_AVG_EN.
- Defined: sample = (r0+r1+r2+r3)>>2, using a 14-bit sum, truncated, where r0..r3 are the last four raw frame values. History registers reset to 0, so the first three outputs after reset include zeros. Latency is unchanged.
- Undefined: sample = raw frame value, and no history registers are synthesized.

Verification
REQ-027 Reset released, en=1, CLK_DIV=2, QUIET_CYC=20, ADC model returns 0x0ABC -> adc_cs low 64 cycles; sample=0xABC, sample_valid one pulse, frame_err=0; period 84+-1 cycles.
REQ-028 threshold=0x800, model returns 0x07FF then 0x0800 -> above=0 after first sample, above=1 after second.
REQ-029 Model drives leading bits 1010, data 0x123 -> sample=0x123, frame_err=1; next clean frame -> frame_err=0.
REQ-030 en dropped at the 8th rising edge -> frame completes, one sample_valid, then IDLE with adc_cs=1, adc_clk=1 and no further frames.
REQ-031 reset asserted at the 5th rising edge -> adc_cs=1 and outputs zero within the same cycle; after release with en=1, the next frame is a full 16 edges.
REQ-032 LOCTAG_ADC_AVG_EN defined, raw samples 0x100,0x200,0x300,0x400 -> sample sequence 0x040, 0x0C0, 0x180, 0x280.
